// File: rtl/vend_ctrl.sv
// Vending controller: IDLE/SELECT/COLLECT/VEND/CHANGE FSM, dispense 1 cycle and change 2 cycles after the paying coin.
// No backpressure; `define VEND_STOCK_EN adds per-slot stock counters and sold_out, otherwise stock is unlimited.
module vend_ctrl #(
  parameter int N_ITEMS = 4,
  parameter int MW = 8,
  parameter int SW = 4,
  localparam int IW = $clog2(N_ITEMS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cfg_we_i,
  input  logic [IW-1:0] cfg_idx_i,
  input  logic [MW-1:0] cfg_price_i,
  input  logic [SW-1:0] cfg_stock_i,
  input  logic          start_i,
  input  logic          item_valid_i,
  input  logic [IW-1:0] item_sel_i,
  input  logic          coin_valid_i,
  input  logic [MW-1:0] coin_val_i,
  input  logic          cancel_i,
  output logic [2:0]    state_o,
  output logic [MW-1:0] credit_o,
  output logic          dispense_o,
  output logic [IW-1:0] dispense_item_o,
  output logic          change_valid_o,
  output logic [MW-1:0] change_amt_o,
  output logic          sold_out_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_COLLECT = 3'd2;
  localparam logic [2:0] S_VEND    = 3'd3;
  localparam logic [2:0] S_CHANGE  = 3'd4;

  // One extra bit so N_ITEMS itself is representable when it is a power of two.
  localparam logic [IW:0] N_LIM = (IW+1)'(N_ITEMS);

  logic [2:0]    state_q, state_d;
  logic [MW-1:0] credit_q, credit_d;
  logic [IW-1:0] item_q, item_d;
  logic [MW-1:0] price_q [N_ITEMS];

  logic          cfg_in_range;
  logic          cfg_wr;
  logic          sel_in_range;
  logic          sel_ok;
  logic          sel_take;
  logic [MW-1:0] item_price;
  logic [MW:0]   coin_sum;
  logic          coin_sat;
  logic [MW-1:0] credit_post;

  assign cfg_in_range = ({1'b0, cfg_idx_i} < N_LIM);
  assign sel_in_range = ({1'b0, item_sel_i} < N_LIM);
  assign cfg_wr       = (state_q == S_IDLE) && cfg_we_i && cfg_in_range;
  assign sel_take     = (state_q == S_SELECT) && !cancel_i && item_valid_i && sel_ok;
  assign item_price   = price_q[item_q];

  // Credit after this cycle's coin; the carry out marks a saturated add.
  assign coin_sum    = {1'b0, credit_q} + (coin_valid_i ? {1'b0, coin_val_i} : '0);
  assign coin_sat    = coin_sum[MW];
  assign credit_post = coin_sat ? '1 : coin_sum[MW-1:0];

`ifdef VEND_STOCK_EN
  logic [SW-1:0] stock_q [N_ITEMS];
  logic          sold_out_q;
  logic          sold_out_d;

  assign sel_ok     = sel_in_range && (stock_q[item_sel_i] != '0);
  assign sold_out_d = (state_q == S_SELECT) && !cancel_i && item_valid_i && !sel_ok;
  assign sold_out_o = sold_out_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= '0;
      sold_out_q <= 1'b0;
    end else begin
      sold_out_q <= sold_out_d;
      if (cfg_wr) begin
        stock_q[cfg_idx_i] <= cfg_stock_i;
      end else if ((state_q == S_VEND) && (stock_q[item_q] != '0)) begin
        stock_q[item_q] <= stock_q[item_q] - SW'(1);
      end
    end
  end
`else
  logic unused_cfg_stock;

  assign unused_cfg_stock = ^cfg_stock_i;
  assign sel_ok           = sel_in_range;
  assign sold_out_o       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_ITEMS; i++) price_q[i] <= '0;
    end else if (cfg_wr) begin
      price_q[cfg_idx_i] <= cfg_price_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_i) state_d = S_SELECT;
      S_SELECT: begin
        if (cancel_i)      state_d = S_IDLE;
        else if (sel_take) state_d = S_COLLECT;
      end
      // Reaching the price wins over saturation and cancel.
      S_COLLECT: begin
        if (credit_post >= item_price)  state_d = S_VEND;
        else if (coin_sat || cancel_i)  state_d = S_CHANGE;
      end
      S_VEND:    state_d = S_CHANGE;
      S_CHANGE:  state_d = start_i ? S_SELECT : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    credit_d = credit_q;
    item_d   = item_q;
    case (state_q)
      S_SELECT:  if (sel_take) item_d = item_sel_i;
      S_COLLECT: credit_d = credit_post;
      S_VEND:    credit_d = credit_q - item_price;
      S_CHANGE:  credit_d = '0;
      default:   credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credit_q <= '0;
      item_q   <= '0;
    end else begin
      credit_q <= credit_d;
      item_q   <= item_d;
    end
  end

  always_comb begin
    dispense_o      = 1'b0;
    dispense_item_o = '0;
    change_valid_o  = 1'b0;
    change_amt_o    = '0;
    case (state_q)
      S_VEND: begin
        dispense_o      = 1'b1;
        dispense_item_o = item_q;
      end
      S_CHANGE: begin
        change_valid_o = 1'b1;
        change_amt_o   = credit_q;
      end
      default: dispense_o = 1'b0;
    endcase
  end

  assign state_o  = state_q;
  assign credit_o = credit_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed purchases checked every cycle against a transaction-level model plus literal spot checks.
module tb_vend_ctrl;

  localparam int NI   = 5;
  localparam int MW   = 8;
  localparam int SW   = 4;
  localparam int IW   = 3;
  localparam int MAXV = 255;
`ifdef VEND_STOCK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          cfg_we, start, item_valid, coin_valid, cancel;
  logic [IW-1:0] cfg_idx, item_sel;
  logic [MW-1:0] cfg_price, coin_val;
  logic [SW-1:0] cfg_stock;
  logic [2:0]    state;
  logic [MW-1:0] credit, change_amt;
  logic          dispense, change_valid, sold_out;
  logic [IW-1:0] dispense_item;

  int nvec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  vend_ctrl #(.N_ITEMS(NI), .MW(MW), .SW(SW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_price_i(cfg_price), .cfg_stock_i(cfg_stock),
    .start_i(start), .item_valid_i(item_valid), .item_sel_i(item_sel),
    .coin_valid_i(coin_valid), .coin_val_i(coin_val), .cancel_i(cancel),
    .state_o(state), .credit_o(credit), .dispense_o(dispense), .dispense_item_o(dispense_item),
    .change_valid_o(change_valid), .change_amt_o(change_amt), .sold_out_o(sold_out)
  );

  // Transaction-level model: credit as a plain integer clamped at MAXV, tables as int arrays.
  int m_st, m_credit, m_item;
  int m_price [NI];
  int m_stock [NI];
  bit m_sold;

  function automatic int coin_amt();
    return coin_valid ? int'(coin_val) : 0;
  endfunction

  function automatic int paid();
    return (m_credit + coin_amt() > MAXV) ? MAXV : m_credit + coin_amt();
  endfunction

  function automatic bit sel_ok(input int s);
    if (s >= NI) return 1'b0;
    return !STK || (m_stock[s] > 0);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_st <= 0; m_credit <= 0; m_item <= 0; m_sold <= 1'b0;
      for (int i = 0; i < NI; i++) begin
        m_price[i] <= 0;
        m_stock[i] <= 0;
      end
    end else begin
      m_sold <= 1'b0;
      case (m_st)
        0: begin
          if (cfg_we && int'(cfg_idx) < NI) begin
            m_price[cfg_idx] <= int'(cfg_price);
            m_stock[cfg_idx] <= int'(cfg_stock);
          end
          if (start) m_st <= 1;
        end
        1: begin
          if (cancel) m_st <= 0;
          else if (item_valid) begin
            if (sel_ok(int'(item_sel))) begin
              m_item <= int'(item_sel);
              m_st   <= 2;
            end else begin
              m_sold <= STK;
            end
          end
        end
        2: begin
          m_credit <= paid();
          if (paid() >= m_price[m_item]) m_st <= 3;
          else if (m_credit + coin_amt() > MAXV || cancel) m_st <= 4;
        end
        3: begin
          m_credit <= m_credit - m_price[m_item];
          if (STK && m_stock[m_item] > 0) m_stock[m_item] <= m_stock[m_item] - 1;
          m_st <= 4;
        end
        4: begin
          m_credit <= 0;
          m_st <= start ? 1 : 0;
        end
        default: m_st <= 0;
      endcase
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("state", 32'(state), m_st);
    check("credit", 32'(credit), m_credit);
    check("dispense", 32'(dispense), (m_st == 3) ? 1 : 0);
    check("dispense_item", 32'(dispense_item), (m_st == 3) ? m_item : 0);
    check("change_valid", 32'(change_valid), (m_st == 4) ? 1 : 0);
    check("change_amt", 32'(change_amt), (m_st == 4) ? m_credit : 0);
    check("sold_out", 32'(sold_out), 32'(m_sold));
  end

  task automatic clr();
    cfg_we = 0; cfg_idx = '0; cfg_price = '0; cfg_stock = '0;
    start = 0; item_valid = 0; item_sel = '0;
    coin_valid = 0; coin_val = '0; cancel = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic cfg(input int idx, input int price, input int stock);
    cfg_we = 1; cfg_idx = IW'(idx); cfg_price = MW'(price); cfg_stock = SW'(stock);
    tick();
  endtask

  task automatic sel(input int idx);
    item_valid = 1; item_sel = IW'(idx);
    tick();
  endtask

  task automatic coin(input int v);
    coin_valid = 1; coin_val = MW'(v);
    tick();
  endtask

  initial begin
    clr();
    #1 reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("lit_rst_state", 32'(state), 0);
    check("lit_rst_credit", 32'(credit), 0);
    reset_n = 1;

    cfg(1, 25, 2); cfg(2, 10, 0); cfg(0, 0, 3); cfg(3, 50, 5); cfg(4, 255, 5);

    // Basic purchase: price 25 paid with three 10s.
    start = 1; tick();
    check("lit_select", 32'(state), 1);
    sel(1);
    check("lit_collect", 32'(state), 2);
    coin(10); coin(10);
    check("lit_credit20", 32'(credit), 20);
    coin(10);
    check("lit_disp", 32'(dispense), 1);
    check("lit_disp_item", 32'(dispense_item), 1);
    tick();
    check("lit_chg_vld", 32'(change_valid), 1);
    check("lit_chg5", 32'(change_amt), 5);
    tick();
    check("lit_idle", 32'(state), 0);

    // Out-of-range then empty slot, then cancel.
    start = 1; tick();
    sel(7);
    check("lit_oor_state", 32'(state), 1);
    check("lit_oor_sold", 32'(sold_out), 32'(STK));
    sel(2);
    check("lit_empty_state", 32'(state), STK ? 1 : 2);
    check("lit_empty_sold", 32'(sold_out), 32'(STK));
    cancel = 1; tick();
    check("lit_cancel_state", 32'(state), STK ? 0 : 4);
    tick();

    // Cancel refund with a coin in the same cycle.
    start = 1; tick();
    sel(3);
    coin(20); coin(20);
    coin_valid = 1; coin_val = 8'd5; cancel = 1; tick();
    check("lit_refund_state", 32'(state), 4);
    check("lit_refund_amt", 32'(change_amt), 45);
    check("lit_refund_nodisp", 32'(dispense), 0);
    tick();

    // Saturation at 255 reaching a 255 price, then back-to-back purchase.
    start = 1; tick();
    sel(4);
    coin(200);
    coin(100);
    check("lit_sat_credit", 32'(credit), 255);
    check("lit_sat_disp", 32'(dispense), 1);
    tick();
    check("lit_sat_chg", 32'(change_amt), 0);
    check("lit_sat_chg_vld", 32'(change_valid), 1);
    start = 1; tick();
    check("lit_b2b_state", 32'(state), 1);
    sel(1);
    check("lit_b2b_credit", 32'(credit), 0);
    coin(25);
    check("lit_b2b_disp", 32'(dispense), 1);
    tick(); tick();

    // Slot 1 has now sold twice; with stock enabled it is empty.
    start = 1; tick();
    sel(1);
    check("lit_stock_state", 32'(state), STK ? 1 : 2);
    check("lit_stock_sold", 32'(sold_out), 32'(STK));
    cancel = 1; tick();
    tick(); tick();

    // Zero-price slot vends with no coin.
    start = 1; tick();
    sel(0);
    tick();
    check("lit_zero_disp", 32'(dispense), 1);
    check("lit_zero_item", 32'(dispense_item), 0);
    tick(); tick();

    // cfg_we outside IDLE is ignored; then reset mid-COLLECT.
    start = 1; tick();
    sel(3);
    cfg_we = 1; cfg_idx = 3'd3; cfg_price = 8'd1; cfg_stock = 4'd9;
    coin(30);
    tick();
    check("lit_cfg_ignored", 32'(state), 2);
    check("lit_credit30", 32'(credit), 30);
    #2 reset_n = 0;
    #1;
    check("lit_rst_mid_state", 32'(state), 0);
    check("lit_rst_mid_credit", 32'(credit), 0);
    check("lit_rst_mid_chg", 32'(change_valid), 0);
    @(posedge clk);
    #1 reset_n = 1;

    // Resume: cfg and start in the same IDLE cycle.
    cfg_we = 1; cfg_idx = 3'd1; cfg_price = 8'd7; cfg_stock = 4'd1; start = 1;
    tick();
    check("lit_resume_state", 32'(state), 1);
    sel(1);
    coin(10);
    tick();
    check("lit_resume_chg", 32'(change_amt), 3);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter N_ITEMS, default 4: number of item slots, legal range 2..16.
REQ-002 Parameter MW, default 8: width of money, price, credit and change.
REQ-003 Parameter SW, default 4: width of each slot's stock counter.
REQ-004 Localparam IW = clog2(N_ITEMS): item index width.
REQ-005 clk  input  1  clock, rising edge. Reset reset_n, asynchronous, active-low; clock clk.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 cfg_we  input  1  write strobe for the price/stock entry of slot cfg_idx.
REQ-008 cfg_idx  input  IW; cfg_price  input  MW; cfg_stock  input  SW: configuration data.
REQ-009 start  input  1  begin a transaction.
REQ-010 item_valid  input  1; item_sel  input  IW: item selection strobe and slot index.
REQ-011 coin_valid  input  1; coin_val  input  MW: one coin of any value per strobed cycle.
REQ-012 cancel  input  1  abort the transaction and refund credit.
REQ-013 state  output  3  current FSM state.
REQ-014 credit  output  MW  accumulated credit register.
REQ-015 dispense  output  1  one-cycle pulse; dispense_item  output  IW  slot being vended.
REQ-016 change_valid  output  1  one-cycle pulse; change_amt  output  MW  change or refund amount.
REQ-017 sold_out  output  1  one-cycle pulse when an empty or invalid slot is selected.

Function
REQ-018 State encoding: IDLE=0, SELECT=1, COLLECT=2, VEND=3, CHANGE=4; codes 5-7 return to IDLE on the next edge.
REQ-019 IDLE: cfg_we writes price[cfg_idx] and stock[cfg_idx] on the edge. cfg_we in any other state is ignored. start moves to SELECT; cfg_we and start in the same cycle perform both actions.
REQ-020 SELECT, valid selection: item_valid with item_sel < N_ITEMS and stock > 0 latches the item and moves to COLLECT.
REQ-021 SELECT, invalid selection: an empty slot or out-of-range index pulses sold_out the next cycle and stays in SELECT.
REQ-022 SELECT, cancel: cancel moves to IDLE and has priority over item_valid.
REQ-023 COLLECT: coin_valid adds coin_val to credit, saturating at 2^MW-1.
REQ-024 COLLECT, exit conditions, evaluated on the post-add credit:
- credit >= price of the latched item moves to VEND;
- a saturated add moves to CHANGE (refund);
- cancel moves to CHANGE, and a coin in the same cycle is still added to the refund.
REQ-025 COLLECT, zero price: a price of 0 moves to VEND one cycle after COLLECT is entered, with no coin required.
REQ-026 VEND:
- dispense = 1 and dispense_item = latched item for exactly one cycle;
- credit -= price and stock -= 1 on exit;
- moves to CHANGE;
- cancel is ignored.
REQ-027 CHANGE:
- change_valid = 1 and change_amt = credit for one cycle (a value of 0 is legal);
- credit clears to 0 on exit;
- start moves to SELECT, otherwise the FSM moves to IDLE.
REQ-028 Output decode: dispense, dispense_item, change_valid and change_amt are Moore outputs decoded from the registered state and registers. They are 0 outside their states.
REQ-029 Latency: the coin edge that reaches the price is followed by dispense one cycle later and change_valid two cycles later.
REQ-030 Arithmetic: all arithmetic is unsigned MW-bit. Stock never decrements below 0.

Reset
REQ-031 Assertion of reset_n asynchronously forces:
- state to IDLE;
- credit, the latched item and all outputs to 0;
- all price and stock entries to 0.
REQ-032 Reset mid-transaction discards credit and produces no change_valid pulse; operation resumes from IDLE on the first edge after deassertion.

Configuration
REQ-033 Macro VEND_STOCK_EN.
- Defined: stock tables, stock decrement and sold_out are implemented.
- Undefined: every slot has unlimited stock, cfg_stock is ignored, sold_out is tied to 0, and only an out-of-range item_sel is rejected (it stays in SELECT with no pulse).

Verification
REQ-034 Setup: cfg slot1 price 25, stock 2; start; select 1; coins 10, 10, 10 -> dispense with item 1 one cycle after the third coin; change_amt 5 on the next cycle; stock[1]=1.
REQ-035 Sold out (VEND_STOCK_EN): slot2 stock 0; select 2 -> sold_out pulse, state remains 1; then cancel -> state 0.
REQ-036 Cancel refund: price 50; coins 20, 20; cancel together with coin 5 -> no dispense; change_amt 45.
REQ-037 Saturation (MW=8): price 255; coins 200 then 100 -> credit 255, dispense, change_amt 0.
REQ-038 Back-to-back: start held during CHANGE -> state SELECT; a second purchase completes with credit starting at 0.
REQ-039 Reset in COLLECT with credit 30 -> state 0, credit 0, no change_valid; a cfg_we issued in COLLECT before the reset left the tables unchanged.
